// File: rtl/spi_mem_reader.sv
// SPI mode-0 slave that streams bytes from a synchronous-read memory, MSB first.
// The next byte is prefetched into a holding buffer while the current one shifts out.
module spi_mem_reader #(
    parameter int unsigned AW         = 8,
    parameter bit          ADDR_PHASE = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sel,
    input  logic          rising,
    input  logic          falling,
    input  logic          si,
    input  logic          reset_flag,
    output logic          so,
    output logic          rd_en,
    output logic [AW-1:0] addr,
    input  logic [7:0]    rd_data,
    output logic          byte_done
);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StPrime,
        StPrimeWait,
        StFetch,
        StFetchWait,
        StShift
    } state_e;

    state_e      state_q;
    logic [7:0]  sr_q;
    logic [7:0]  buf_q;
    logic [2:0]  bit_cnt_q;
    logic        sel_q;
    logic        seen_rise_q;
    logic [7:0]  sr_in;

    assign sr_in = {sr_q[6:0], si};
    assign so    = sel & sr_q[7];

    // rd_en is raised on entry to PRIME/FETCH, so it is high during the state's
    // first cycle; addr advances on the edge where the memory samples it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            sr_q        <= 8'h00;
            buf_q       <= 8'h00;
            bit_cnt_q   <= 3'd0;
            sel_q       <= 1'b0;
            seen_rise_q <= 1'b0;
            addr        <= '0;
            rd_en       <= 1'b0;
            byte_done   <= 1'b0;
        end else begin
            sel_q     <= sel;
            rd_en     <= 1'b0;
            byte_done <= 1'b0;

            if (rd_en) begin
                addr <= addr + 1'b1;
            end

            if (state_q != StIdle && !sel) begin
                state_q   <= StIdle;
                bit_cnt_q <= 3'd0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (sel && !sel_q) begin
                            seen_rise_q <= 1'b0;
                            bit_cnt_q   <= 3'd0;
                            if (ADDR_PHASE) begin
                                state_q <= StAddr;
                            end else begin
                                state_q <= StPrime;
                                rd_en   <= 1'b1;
                            end
                        end
                    end

                    StAddr: begin
                        if (rising) begin
                            sr_q        <= sr_in;
                            seen_rise_q <= 1'b1;
                            if (bit_cnt_q == 3'd7) begin
                                addr      <= sr_in[AW-1:0];
                                bit_cnt_q <= 3'd0;
                                state_q   <= StFetch;
                                rd_en     <= 1'b1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                            end
                        end
                    end

                    StPrime: begin
                        state_q <= StPrimeWait;
                    end

                    StPrimeWait: begin
                        sr_q    <= rd_data;
                        state_q <= StFetch;
                        rd_en   <= 1'b1;
                    end

                    StFetch, StFetchWait, StShift: begin
                        if (state_q == StFetch) begin
                            state_q <= StFetchWait;
                        end
                        if (state_q == StFetchWait) begin
                            buf_q   <= rd_data;
                            state_q <= StShift;
                        end
                        if (rising) begin
                            seen_rise_q <= 1'b1;
                            bit_cnt_q   <= bit_cnt_q + 3'd1;
                            byte_done   <= (bit_cnt_q == 3'd7);
                        end else if (falling) begin
                            if (bit_cnt_q != 3'd0) begin
                                sr_q <= {sr_q[6:0], 1'b0};
                            end else if (seen_rise_q && state_q != StFetch) begin
                                // Load can land while the fetch is still in its data
                                // cycle; the byte is then taken straight off rd_data.
                                sr_q    <= (state_q == StShift) ? buf_q : rd_data;
                                state_q <= StFetch;
                                rd_en   <= 1'b1;
                            end
                        end
                    end

                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end

            if (reset_flag) begin
                addr <= '0;
            end
        end
    end

endmodule
